enhanced_cu: RTL and testbench

ENHANCED_CU -- requirements
Module: enhanced_cu

---
 rtl/enhanced_cu_pkg.sv | 66 ++++++
 rtl/ecu_wait_timer.sv | 36 +++
 rtl/enhanced_cu.sv | 188 ++++++++++++++++++
 tb/tb_enhanced_cu.sv | 470 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enhanced_cu_pkg.sv
// Shared encodings for the enhanced control unit: opcodes, 5-bit state codes,
// ALU operation and A-mux select codes.
package enhanced_cu_pkg;

  typedef enum logic [3:0] {
    OP_LOAD  = 4'd0,
    OP_STORE = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_INPUT = 4'd4,
    OP_JZ    = 4'd5,
    OP_JPOS  = 4'd6,
    OP_HALT  = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_NOT   = 4'd10,
    OP_INC   = 4'd11,
    OP_DEC   = 4'd12,
    OP_JMP   = 4'd13,
    OP_JNZ   = 4'd14,
    OP_NOP   = 4'd15
  } opcode_e;

  typedef enum logic [4:0] {
    S_START  = 5'd0,
    S_FETCH  = 5'd1,
    S_DECODE = 5'd2,
    S_MEMOP  = 5'd3,
    S_ALU1   = 5'd4,
    S_JUMP   = 5'd5,
    S_INPUT  = 5'd6,
    S_HALT   = 5'd7,
    S_FAULT  = 5'd8,
    S_IRQ    = 5'd9
  } state_e;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_NOT  = 3'b100;
  localparam logic [2:0] ALU_INC  = 3'b101;
  localparam logic [2:0] ALU_DEC  = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  localparam logic [1:0] ASEL_ALU = 2'b00;
  localparam logic [1:0] ASEL_IN  = 2'b01;
  localparam logic [1:0] ASEL_MEM = 2'b10;

  // Wide enough for the largest allowed WAIT_MAX (255).
  localparam int WAIT_W = 8;

  function automatic logic [2:0] alu_op_of(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_NOT:  return ALU_NOT;
      OP_INC:  return ALU_INC;
      OP_DEC:  return ALU_DEC;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/ecu_wait_timer.sv
// Memory-wait timeout counter: held at zero while cleared, counts stalled
// cycles otherwise, and flags when the count has reached WAIT_MAX.
module ecu_wait_timer
  import enhanced_cu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WAIT_W'(WAIT_MAX));

endmodule

// File: rtl/enhanced_cu.sv
// Multi-cycle control unit with memory-wait timeout and illegal-opcode fault.
// Define ENHANCED_CU_IRQ_EN to enable the single-cycle interrupt entry state.
module enhanced_cu
  import enhanced_cu_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic           Enter,
  input  logic           Aeq0,
  input  logic           Apos,
  input  logic [OPW-1:0] IR,
  input  logic           MemReady,
  input  logic           Irq,
  output logic           IRload,
  output logic           PCload,
  output logic           JMPmux,
  output logic           Meminst,
  output logic           MemWr,
  output logic           MemReq,
  output logic           Aload,
  output logic [1:0]     Asel,
  output logic [2:0]     AluOp,
  output logic           Halt,
  output logic           Fault,
  output logic           IrqAck,
  output logic [4:0]     state
);

  state_e  state_q, state_d;
  opcode_e op;
  logic    illegal;
  logic    in_wait;
  logic    wait_expired;
  logic    timeout;
  logic    irq_take;

  assign op      = opcode_e'(IR[3:0]);
  assign illegal = (IR >> 4) != '0;

  // Memory handshake: MemReq is the request valid, MemReady the completion.
  // MemReq is high in exactly FETCH and MEMOP, so MemReady is only looked at there.
  assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMOP);
  assign timeout = in_wait && !MemReady && wait_expired;

  ecu_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .Clock   (Clock),
    .Reset   (Reset),
    .clear   (!in_wait),
    .inc     (in_wait && !MemReady),
    .expired (wait_expired)
  );

`ifdef ENHANCED_CU_IRQ_EN
  logic irq_busy_q, irq_busy_d;

  // Busy blocks re-entry while the same level request stays asserted.
  always_comb begin
    irq_busy_d = irq_busy_q;
    if (state_q == S_START && !Irq) irq_busy_d = 1'b0;
    if (state_q == S_IRQ)           irq_busy_d = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      irq_busy_q <= 1'b0;
    end else begin
      irq_busy_q <= irq_busy_d;
    end
  end

  assign irq_take = (state_q == S_START) && Irq && !irq_busy_q;
`else
  logic unused_irq;
  assign unused_irq = Irq;
  assign irq_take   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_START:  state_d = irq_take ? S_IRQ : S_FETCH;
      S_IRQ:    state_d = S_FETCH;
      S_FETCH: begin
        if (MemReady)     state_d = S_DECODE;
        else if (timeout) state_d = S_FAULT;
      end
      S_DECODE: begin
        if (illegal) begin
          state_d = S_FAULT;
        end else begin
          case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_MEMOP;
            OP_NOT, OP_INC, OP_DEC:                           state_d = S_ALU1;
            OP_JZ, OP_JPOS, OP_JMP, OP_JNZ:                   state_d = S_JUMP;
            OP_INPUT:                                         state_d = S_INPUT;
            OP_HALT:                                          state_d = S_HALT;
            OP_NOP:                                           state_d = S_START;
            default:                                          state_d = S_FAULT;
          endcase
        end
      end
      S_MEMOP: begin
        if (MemReady)     state_d = S_START;
        else if (timeout) state_d = S_FAULT;
      end
      S_ALU1, S_JUMP: state_d = S_START;
      S_INPUT:        if (Enter) state_d = S_START;
      S_HALT, S_FAULT: state_d = state_q;
      default:        state_d = S_START;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_START;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    IRload  = 1'b0;
    PCload  = 1'b0;
    JMPmux  = 1'b0;
    Meminst = 1'b0;
    MemWr   = 1'b0;
    MemReq  = 1'b0;
    Aload   = 1'b0;
    Asel    = ASEL_ALU;
    AluOp   = ALU_ADD;
    Halt    = 1'b0;
    Fault   = 1'b0;
    IrqAck  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemReq = 1'b1;
        IRload = MemReady;
        PCload = MemReady;
      end
      S_DECODE: Meminst = 1'b1;
      S_MEMOP: begin
        MemReq  = 1'b1;
        Meminst = 1'b1;
        MemWr   = (op == OP_STORE);
        if (MemReady && op == OP_LOAD) begin
          Aload = 1'b1;
          Asel  = ASEL_MEM;
        end else if (MemReady && op != OP_STORE) begin
          Aload = 1'b1;
          AluOp = alu_op_of(op);
        end
      end
      S_ALU1: begin
        Aload = 1'b1;
        AluOp = alu_op_of(op);
      end
      S_JUMP: begin
        JMPmux = 1'b1;
        case (op)
          OP_JZ:   PCload = Aeq0;
          OP_JPOS: PCload = Apos;
          OP_JNZ:  PCload = !Aeq0;
          OP_JMP:  PCload = 1'b1;
          default: PCload = 1'b0;
        endcase
      end
      S_INPUT: begin
        Aload = 1'b1;
        Asel  = ASEL_IN;
      end
      S_HALT:  Halt  = 1'b1;
      S_FAULT: Fault = 1'b1;
`ifdef ENHANCED_CU_IRQ_EN
      S_IRQ: begin
        IrqAck = 1'b1;
        PCload = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_enhanced_cu.sv
// Scenario bench for enhanced_cu: per-cycle expected output vectors are queued
// as stimulus is applied and compared against the DUT on the falling edge.
module tb_enhanced_cu;
  import enhanced_cu_pkg::*;

  localparam int OPW      = 5;
  localparam int WAIT_MAX = 15;

  // Observed vector layout: {state, IRload, PCload, JMPmux, Meminst, MemWr,
  // MemReq, Aload, Asel[1:0], AluOp[2:0], Halt, Fault, IrqAck}
  localparam logic [19:0] M_ACK = 20'h00001;
  localparam logic [19:0] M_FLT = 20'h00002;
  localparam logic [19:0] M_HLT = 20'h00004;
  localparam logic [19:0] M_AL  = 20'h00100;
  localparam logic [19:0] M_MQ  = 20'h00200;
  localparam logic [19:0] M_MW  = 20'h00400;
  localparam logic [19:0] M_MI  = 20'h00800;
  localparam logic [19:0] M_JMP = 20'h01000;
  localparam logic [19:0] M_PCL = 20'h02000;
  localparam logic [19:0] M_IRL = 20'h04000;
  localparam logic [19:0] M_ACC = M_IRL | M_PCL | M_MQ;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           Enter, Aeq0, Apos, MemReady, Irq;
  logic [OPW-1:0] IR;
  logic           IRload, PCload, JMPmux, Meminst, MemWr, MemReq, Aload;
  logic [1:0]     Asel;
  logic [2:0]     AluOp;
  logic           Halt, Fault, IrqAck;
  logic [4:0]     state_o;

  int checks   = 0;
  int failures = 0;

  logic [19:0] exp_q[$];
  logic [9:0]  plan_st[$];
  logic [19:0] plan_ex[$];
  logic [19:0] obs;

  enhanced_cu #(.OPW(OPW), .WAIT_MAX(WAIT_MAX)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enter    (Enter),
    .Aeq0     (Aeq0),
    .Apos     (Apos),
    .IR       (IR),
    .MemReady (MemReady),
    .Irq      (Irq),
    .IRload   (IRload),
    .PCload   (PCload),
    .JMPmux   (JMPmux),
    .Meminst  (Meminst),
    .MemWr    (MemWr),
    .MemReq   (MemReq),
    .Aload    (Aload),
    .Asel     (Asel),
    .AluOp    (AluOp),
    .Halt     (Halt),
    .Fault    (Fault),
    .IrqAck   (IrqAck),
    .state    (state_o)
  );

  // Clock / reset
  always #5 Clock = ~Clock;

  assign obs = {state_o, IRload, PCload, JMPmux, Meminst, MemWr, MemReq, Aload,
                Asel, AluOp, Halt, Fault, IrqAck};

  function automatic logic [9:0] si(input int ir, input logic mr, input logic en = 1'b0,
                                    input logic z = 1'b0, input logic p = 1'b0,
                                    input logic irq = 1'b0);
    logic [4:0] irv;
    irv = 5'(ir);
    return {irq, en, z, p, mr, irv};
  endfunction

  function automatic logic [19:0] ev(input logic [4:0] st, input logic [19:0] m,
                                     input logic [1:0] asel = 2'b00,
                                     input logic [2:0] alu = 3'b000);
    return {st, 15'd0} | m | {12'd0, asel, 6'd0} | {14'd0, alu, 3'd0};
  endfunction

  // Driver tasks
  task automatic drive_in(input logic [9:0] s);
    {Irq, Enter, Aeq0, Apos, MemReady, IR} = s;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    drive_in('0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  task automatic plan(input logic [9:0] s, input logic [19:0] e);
    plan_st.push_back(s);
    plan_ex.push_back(e);
  endtask

  task automatic plan_clear();
    plan_st.delete();
    plan_ex.delete();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive_in(si(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    #2;
    checks++;
    if (obs !== ev(S_START, '0)) begin
      failures++;
      $display("FAIL reset_async got=%h exp=%h", obs, ev(S_START, '0));
    end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    @(negedge Clock);
    checks++;
    if (obs !== ev(S_START, '0)) begin
      failures++;
      $display("FAIL reset_start got=%h exp=%h", obs, ev(S_START, '0));
    end
    drive_in('0);
  endtask

  task automatic test_add_late();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(2, 1'b0), ev(S_FETCH, M_MQ));
    plan(si(2, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(2, 1'b0), ev(S_DECODE, M_MI));
    plan(si(2, 1'b0), ev(S_MEMOP, M_MQ | M_MI));
    plan(si(2, 1'b0), ev(S_MEMOP, M_MQ | M_MI));
    plan(si(2, 1'b1), ev(S_MEMOP, M_MQ | M_MI | M_AL, 2'b00, 3'b000));
    plan(si(2, 1'b0), ev(S_START, '0));
    plan(si(2, 1'b0), ev(S_FETCH, M_MQ));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL add_late cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_memops();
    logic [19:0] want, m, wm;
    logic [1:0]  a;
    logic [2:0]  u;
    int          op;
    do_reset();
    plan_clear();
    for (int k = 0; k < 5; k++) begin
      a = 2'b00; u = 3'b000; m = M_MQ | M_MI | M_AL;
      case (k)
        0: begin op = 0; a = 2'b10; end
        1: begin op = 1; m = M_MQ | M_MI | M_MW; end
        2: begin op = 3; u = 3'b001; end
        3: begin op = 8; u = 3'b010; end
        default: begin op = 9; u = 3'b011; end
      endcase
      wm = (op == 1) ? M_MW : 20'h0;
      plan(si(op, 1'b1), ev(S_FETCH, M_ACC));
      plan(si(op, 1'b0), ev(S_DECODE, M_MI));
      plan(si(op, 1'b0), ev(S_MEMOP, M_MQ | M_MI | wm));
      plan(si(op, 1'b1), ev(S_MEMOP, m, a, u));
      plan(si(op, 1'b0), ev(S_START, '0));
    end
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL memops cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_alu1_nop();
    logic [19:0] want;
    do_reset();
    plan_clear();
    for (int k = 0; k < 3; k++) begin
      plan(si(10 + k, 1'b1), ev(S_FETCH, M_ACC));
      plan(si(10 + k, 1'b0), ev(S_DECODE, M_MI));
      plan(si(10 + k, 1'b1), ev(S_ALU1, M_AL, 2'b00, 3'(4 + k)));
      plan(si(10 + k, 1'b0), ev(S_START, '0));
    end
    plan(si(15, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0), ev(S_START, '0));
    plan(si(15, 1'b0), ev(S_FETCH, M_MQ));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL alu1_nop cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_jumps();
    logic [19:0] want;
    int j_op [7] = '{5, 5, 6, 6, 14, 14, 13};
    int j_z  [7] = '{1, 0, 0, 1, 1, 0, 0};
    int j_p  [7] = '{0, 1, 1, 0, 1, 0, 0};
    int j_pc [7] = '{1, 0, 1, 0, 0, 1, 1};
    do_reset();
    plan_clear();
    for (int k = 0; k < 7; k++) begin
      plan(si(j_op[k], 1'b1), ev(S_FETCH, M_ACC));
      plan(si(j_op[k], 1'b0), ev(S_DECODE, M_MI));
      plan(si(j_op[k], 1'b0, 1'b0, 1'(j_z[k]), 1'(j_p[k])),
           ev(S_JUMP, M_JMP | ((j_pc[k] != 0) ? M_PCL : 20'h0)));
      plan(si(j_op[k], 1'b0), ev(S_START, '0));
    end
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL jumps cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_input();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(4, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(4, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    for (int k = 0; k < 5; k++) begin
      plan(si(4, 1'(k % 2)), ev(S_INPUT, M_AL, 2'b01));
    end
    plan(si(4, 1'b0, 1'b1), ev(S_INPUT, M_AL, 2'b01));
    plan(si(4, 1'b0), ev(S_START, '0));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL input cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_fetch_timeout();
    logic [19:0] want;
    do_reset();
    plan_clear();
    for (int k = 0; k < WAIT_MAX + 1; k++) plan(si(2, 1'b0), ev(S_FETCH, M_MQ));
    plan(si(2, 1'b0), ev(S_FAULT, M_FLT));
    plan(si(2, 1'b1, 1'b1), ev(S_FAULT, M_FLT));
    plan(si(2, 1'b1), ev(S_FAULT, M_FLT));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL fetch_timeout cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_memop_timeout();
    logic [19:0] want;
    do_reset();
    plan_clear();
    for (int k = 0; k < WAIT_MAX; k++) plan(si(2, 1'b0), ev(S_FETCH, M_MQ));
    plan(si(2, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(2, 1'b0), ev(S_DECODE, M_MI));
    for (int k = 0; k < WAIT_MAX + 1; k++) plan(si(2, 1'b0), ev(S_MEMOP, M_MQ | M_MI));
    plan(si(2, 1'b0), ev(S_FAULT, M_FLT));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL memop_timeout cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_illegal();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(16, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(16, 1'b0), ev(S_DECODE, M_MI));
    plan(si(16, 1'b1), ev(S_FAULT, M_FLT));
    plan(si(0, 1'b1, 1'b1), ev(S_FAULT, M_FLT));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL illegal cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_halt();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(7, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(7, 1'b0), ev(S_DECODE, M_MI));
    plan(si(7, 1'b0), ev(S_HALT, M_HLT));
    plan(si(7, 1'b1, 1'b1), ev(S_HALT, M_HLT));
    plan(si(2, 1'b1), ev(S_HALT, M_HLT));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_irq();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_START, '0));
`ifdef ENHANCED_CU_IRQ_EN
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_IRQ, M_ACK | M_PCL));
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_START, '0));
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), ev(S_START, '0));
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_START, '0));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_IRQ, M_ACK | M_PCL));
`else
    plan(si(15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_DECODE, M_MI));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_START, '0));
    plan(si(15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), ev(S_FETCH, M_MQ));
`endif
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL irq cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  task automatic test_reset_mid_memop();
    logic [19:0] want;
    do_reset();
    plan_clear();
    plan(si(2, 1'b1), ev(S_FETCH, M_ACC));
    plan(si(2, 1'b0), ev(S_DECODE, M_MI));
    for (int k = 0; k < 3; k++) plan(si(2, 1'b0), ev(S_MEMOP, M_MQ | M_MI));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL mid_memop_pre cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
    #2;
    Reset = 1'b1;
    drive_in(si(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1));
    #1;
    checks++;
    if (obs !== ev(S_START, '0)) begin
      failures++;
      $display("FAIL mid_memop_reset got=%h exp=%h", obs, ev(S_START, '0));
    end
    @(posedge Clock); #1;
    Reset = 1'b0;
    drive_in(si(2, 1'b0));
    plan_clear();
    for (int k = 0; k < WAIT_MAX + 1; k++) plan(si(2, 1'b0), ev(S_FETCH, M_MQ));
    plan(si(2, 1'b0), ev(S_FAULT, M_FLT));
    foreach (plan_st[i]) begin
      @(posedge Clock); #1;
      drive_in(plan_st[i]);
      exp_q.push_back(plan_ex[i]);
      @(negedge Clock);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        failures++;
        $display("FAIL mid_memop_post cyc=%0d got=%h exp=%h", i, obs, want);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    drive_in('0);
    test_reset();
    test_add_late();
    test_memops();
    test_alu1_nop();
    test_jumps();
    test_input();
    test_fetch_timeout();
    test_memop_timeout();
    test_illegal();
    test_halt();
    test_irq();
    test_reset_mid_memop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
